// File: rtl/approx_rc_adder_seq.sv
// approx_rc_adder_seq
//   Sequential ripple-carry adder that processes CHUNK bit positions per
//   cycle. The low APPROX_BITS positions use an approximate full-adder cell
//   unless the operation was launched with in_exact=1. A shadow exact chain
//   runs alongside, so the signed error (exact - approximate) is produced
//   together with the sum.
//
//   Ports
//     clk        rising-edge clock
//     rst_n      synchronous active-low reset
//     in_valid   operand pair offered
//     in_ready   high only in IDLE
//     in_a/in_b  unsigned operands, WIDTH bits
//     in_exact   1 = all positions use exact cells for this operation
//     out_valid  high only in HOLD
//     out_ready  consumer accepts the result
//     out_sum    WIDTH+1 bit sum, MSB is the final carry
//     out_err    WIDTH+2 bit signed error, exact sum minus out_sum
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for an operand pair, in_ready=1
//   RUN    | chunk chunk_idx of both chains is evaluated this cycle
//   HOLD   | result presented on out_sum/out_err until out_ready
module approx_rc_adder_seq #(
    parameter int WIDTH       = 8,
    parameter int APPROX_BITS = 6,
    parameter int CHUNK       = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_exact,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH:0]     out_sum,
    output logic [WIDTH+1:0]   out_err
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST_CHUNK = CW'(NCHUNK - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             exact_r;
    logic [CW-1:0]    chunk_idx;
    logic             c_apx;
    logic             c_ex;
    logic [WIDTH-1:0] s_apx;
    logic [WIDTH-1:0] s_ex;
    logic [WIDTH:0]   sum_r;
    logic [WIDTH+1:0] err_r;

    // combinational evaluation of the current chunk
    int               base;
    logic [CHUNK-1:0] a_chk;
    logic [CHUNK-1:0] b_chk;
    logic [CHUNK-1:0] cs_apx;
    logic [CHUNK-1:0] cs_ex;
    logic             cn_apx;
    logic             cn_ex;
    logic [WIDTH-1:0] chunk_mask;
    logic [WIDTH-1:0] nx_apx;
    logic [WIDTH-1:0] nx_ex;
    logic [WIDTH+1:0] err_nx;

    always_comb begin
        base   = int'(chunk_idx) * CHUNK;
        a_chk  = CHUNK'(a_r >> base);
        b_chk  = CHUNK'(b_r >> base);
        cn_apx = c_apx;
        cn_ex  = c_ex;
        cs_apx = '0;
        cs_ex  = '0;
        for (int j = 0; j < CHUNK; j++) begin
            if (!exact_r && ((base + j) < APPROX_BITS)) begin
                // approximate cell: carry out simply forwards the a bit
                cs_apx[j] = (~a_chk[j] & b_chk[j]) | (a_chk[j] & b_chk[j] & cn_apx);
                cn_apx    = a_chk[j];
            end else begin
                cs_apx[j] = a_chk[j] ^ b_chk[j] ^ cn_apx;
                cn_apx    = (a_chk[j] & b_chk[j]) | (a_chk[j] & cn_apx) | (b_chk[j] & cn_apx);
            end
            cs_ex[j] = a_chk[j] ^ b_chk[j] ^ cn_ex;
            cn_ex    = (a_chk[j] & b_chk[j]) | (a_chk[j] & cn_ex) | (b_chk[j] & cn_ex);
        end
        // merge this chunk into the partial sums so the last cycle can form
        // the complete result without waiting an extra cycle
        chunk_mask = WIDTH'({CHUNK{1'b1}}) << base;
        nx_apx     = (s_apx & ~chunk_mask) | (WIDTH'(cs_apx) << base);
        nx_ex      = (s_ex  & ~chunk_mask) | (WIDTH'(cs_ex)  << base);
        err_nx     = {1'b0, cn_ex, nx_ex} - {1'b0, cn_apx, nx_apx};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            a_r       <= '0;
            b_r       <= '0;
            exact_r   <= 1'b0;
            chunk_idx <= '0;
            c_apx     <= 1'b0;
            c_ex      <= 1'b0;
            s_apx     <= '0;
            s_ex      <= '0;
            sum_r     <= '0;
            err_r     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_r       <= in_a;
                        b_r       <= in_b;
                        exact_r   <= in_exact;
                        chunk_idx <= '0;
                        c_apx     <= 1'b0;
                        c_ex      <= 1'b0;
                        state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    s_apx <= nx_apx;
                    s_ex  <= nx_ex;
                    c_apx <= cn_apx;
                    c_ex  <= cn_ex;
                    if (chunk_idx == LAST_CHUNK) begin
                        sum_r <= {cn_apx, nx_apx};
                        err_r <= err_nx;
                        state <= S_HOLD;
                    end else begin
                        chunk_idx <= chunk_idx + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_HOLD);
    assign out_sum   = sum_r;
    assign out_err   = err_r;

endmodule

// File: tb/tb_approx_rc_adder_seq.sv
// Testbench for approx_rc_adder_seq: directed checks on a default-parameter
// instance plus a scoreboarded random regression over several parameter sets.
module tb_approx_rc_adder_seq;

    localparam int NCFG = 4;
    localparam int NOPS = 2500;
    localparam int CFG_W  [NCFG] = '{8, 16, 16, 8};
    localparam int CFG_AB [NCFG] = '{6, 4, 16, 0};
    localparam int CFG_CH [NCFG] = '{2, 4, 2, 1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit done_cfg [NCFG];
    bit dir_done = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain ripple over the bits, exact sum by integer addition.
    function automatic void ref_add(input int w, input int ab, input logic [63:0] a,
                                    input logic [63:0] b, input bit ex,
                                    output logic [65:0] sum, output logic [66:0] err);
        logic c, x, y;
        logic [65:0] exact;
        c = 1'b0;
        sum = '0;
        for (int i = 0; i < w; i++) begin
            x = a[i];
            y = b[i];
            if (!ex && i < ab) begin
                sum[i] = (~x & y) | (x & y & c);
                c = x;
            end else begin
                sum[i] = x ^ y ^ c;
                c = (x & y) | (x & c) | (y & c);
            end
        end
        sum[w] = c;
        exact = 66'(a) + 66'(b);
        err = 67'(exact) - 67'(sum);
    endfunction

    // ---------------- directed instance (defaults) ----------------
    logic       rst_n_d = 1'b0;
    logic       d_iv = 1'b0, d_ir, d_ov, d_ordy = 1'b0, d_ex = 1'b0;
    logic [7:0] d_a = '0, d_b = '0;
    logic [8:0] d_sum;
    logic [9:0] d_err;

    approx_rc_adder_seq u_dir (
        .clk(clk), .rst_n(rst_n_d), .in_valid(d_iv), .in_ready(d_ir),
        .in_a(d_a), .in_b(d_b), .in_exact(d_ex), .out_valid(d_ov),
        .out_ready(d_ordy), .out_sum(d_sum), .out_err(d_err)
    );

    task automatic d_op(input string name, input logic [7:0] a, input logic [7:0] b,
                        input logic ex, input logic [8:0] es, input logic [9:0] ee);
        @(negedge clk);
        d_a = a; d_b = b; d_ex = ex; d_iv = 1'b1;
        @(posedge clk); #1;
        d_iv = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            chk($sformatf("%s_valid_c%0d", name, k), d_ov, (k == 4));
        end
        chk({name, "_sum"}, d_sum, es);
        chk({name, "_err"}, d_err, ee);
        @(negedge clk);
        d_ordy = 1'b1;
        @(posedge clk); #1;
        d_ordy = 1'b0;
        chk({name, "_release_valid"}, d_ov, 1'b0);
        chk({name, "_release_ready"}, d_ir, 1'b1);
    endtask

    initial begin : directed
        int t;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", d_ir, 1'b1);
        chk("rst_out_valid", d_ov, 1'b0);
        chk("rst_out_sum", d_sum, 9'h000);
        chk("rst_out_err", d_err, 10'h000);
        rst_n_d = 1'b1;

        d_op("a03_b01", 8'h03, 8'h01, 1'b0, 9'h000, 10'd4);
        d_op("aff_b01", 8'hFF, 8'h01, 1'b0, 9'h100, 10'd0);
        d_op("a00_bff", 8'h00, 8'hFF, 1'b0, 9'h0FF, 10'd0);
        d_op("a03_b01_exact", 8'h03, 8'h01, 1'b1, 9'h004, 10'd0);
        d_op("a20_b00_neg", 8'h20, 8'h00, 1'b0, 9'h040, 10'h3E0);

        // backpressure in HOLD with a competing offer
        @(negedge clk);
        d_a = 8'h03; d_b = 8'h01; d_ex = 1'b0; d_iv = 1'b1;
        @(posedge clk); #1;
        d_iv = 1'b0;
        t = 0;
        @(negedge clk);
        while (!d_ov && t < 20) begin @(negedge clk); t++; end
        chk("hold_reached", d_ov, 1'b1);
        d_iv = 1'b1; d_a = 8'h55; d_b = 8'hAA;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("hold_valid_%0d", k), d_ov, 1'b1);
            chk($sformatf("hold_ready_%0d", k), d_ir, 1'b0);
            chk($sformatf("hold_sum_%0d", k), d_sum, 9'h000);
            chk($sformatf("hold_err_%0d", k), d_err, 10'd4);
        end
        d_iv = 1'b0;
        d_ordy = 1'b1;
        @(posedge clk); #1;
        d_ordy = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("hold_no_second_result", d_ov, 1'b0);
        chk("hold_idle_ready", d_ir, 1'b1);

        // reset in the second RUN cycle
        @(negedge clk);
        d_a = 8'h77; d_b = 8'h22; d_ex = 1'b1; d_iv = 1'b1;
        @(posedge clk); #1;
        d_iv = 1'b0;
        @(posedge clk); #1;
        rst_n_d = 1'b0;
        @(posedge clk); #1;
        chk("midrst_ready", d_ir, 1'b1);
        chk("midrst_valid", d_ov, 1'b0);
        chk("midrst_sum", d_sum, 9'h000);
        chk("midrst_err", d_err, 10'h000);
        rst_n_d = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("midrst_no_result", d_ov, 1'b0);
        d_op("post_rst", 8'hFF, 8'h01, 1'b0, 9'h100, 10'd0);
        dir_done = 1'b1;
    end

    // ---------------- random regression instances ----------------
    logic rst_n_r = 1'b0;
    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n_r = 1'b1;
    end

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int W  = CFG_W[g];
        localparam int AB = CFG_AB[g];
        localparam int CH = CFG_CH[g];

        logic           iv = 1'b0, ir, ov, ordy = 1'b0, ex = 1'b0;
        logic [W-1:0]   a = '0, b = '0;
        logic [W:0]     s;
        logic [W+1:0]   e;
        logic [W:0]     q_sum [$];
        logic [W+1:0]   q_err [$];

        approx_rc_adder_seq #(.WIDTH(W), .APPROX_BITS(AB), .CHUNK(CH)) u_dut (
            .clk(clk), .rst_n(rst_n_r), .in_valid(iv), .in_ready(ir),
            .in_a(a), .in_b(b), .in_exact(ex), .out_valid(ov),
            .out_ready(ordy), .out_sum(s), .out_err(e)
        );

        initial begin : drv
            logic [65:0] fs;
            logic [66:0] fe;
            int t;
            wait (rst_n_r);
            for (int n = 0; n < NOPS; n++) begin
                case (n % 8)
                    0: begin a = '1; b = W'(1); end
                    1: begin a = '0; b = '1; end
                    2: begin a = '1; b = '1; end
                    default: begin
                        a = W'({$urandom, $urandom});
                        b = W'({$urandom, $urandom});
                    end
                endcase
                ex = ($urandom_range(0, 3) == 0);
                ref_add(W, AB, 64'(a), 64'(b), ex, fs, fe);
                q_sum.push_back(fs[W:0]);
                q_err.push_back(fe[W+1:0]);
                iv = 1'b1;
                t = 0;
                @(negedge clk);
                while (!ir && t < 200) begin @(negedge clk); t++; end
                if (!ir) begin
                    chk($sformatf("cfg%0d_accept_timeout", g), ir, 1'b1);
                    break;
                end
                @(posedge clk); #1;
                iv = 1'b0;
                repeat ($urandom_range(0, 1)) @(posedge clk);
            end
            iv = 1'b0;
        end

        initial begin : mon
            int got;
            int idle;
            logic [W:0]   es;
            logic [W+1:0] ee;
            got = 0;
            idle = 0;
            wait (rst_n_r);
            while (got < NOPS) begin
                @(negedge clk);
                ordy = ($urandom_range(0, 3) != 0);
                if (ov) begin
                    idle = 0;
                    if (ordy) begin
                        if (q_sum.size() == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL cfg%0d_extra_result: sum %0h with no expected entry", g, s);
                        end else begin
                            es = q_sum.pop_front();
                            ee = q_err.pop_front();
                            chk($sformatf("cfg%0d_sum_%0d", g, got), s, es);
                            chk($sformatf("cfg%0d_err_%0d", g, got), e, ee);
                        end
                        got++;
                    end
                end else begin
                    idle++;
                end
                if (idle > 400) begin
                    chk($sformatf("cfg%0d_result_timeout", g), got, NOPS);
                    break;
                end
            end
            ordy = 1'b0;
            done_cfg[g] = 1'b1;
        end
    end

    initial begin : finisher
        bit all_done;
        all_done = 1'b0;
        for (int c = 0; c < 90000 && !all_done; c++) begin
            @(posedge clk);
            all_done = dir_done;
            for (int g = 0; g < NCFG; g++) all_done = all_done & done_cfg[g];
        end
        if (!all_done) chk("global_timeout", all_done, 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/approx_rc_adder_seq.md
APPROX_RC_ADDER_SEQ -- requirements
Module: approx_rc_adder_seq

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits; SHALL be 2..64.
REQ-002 Parameter APPROX_BITS, default 6: number of LSB positions using approximate cells; SHALL be 0..WIDTH.
REQ-003 Parameter CHUNK, default 2: bit positions processed per cycle; WIDTH mod CHUNK SHALL be 0.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-006 in_valid  in  1  operand pair offered.
REQ-007 in_ready  out  1  block can accept an operand pair.
REQ-008 in_a, in_b  in  WIDTH each  unsigned operands.
REQ-009 in_exact  in  1  1 = every position uses an exact full adder for this operation.
REQ-010 out_valid  out  1  result available.
REQ-011 out_ready  in  1  consumer accepts the result.
REQ-012 out_sum  out  WIDTH+1  approximate (or exact) sum; the MSB is the final carry.
REQ-013 out_err  out  WIDTH+2  signed two's-complement error: exact sum minus out_sum.

Function
REQ-014 Approx cell (X=a bit, Y=b bit, Z=carry in): Cout = X; S = (~X & Y) | (X & Y & Z).
REQ-015 Exact cell: S = X^Y^Z; Cout = majority(X,Y,Z).
REQ-016 Position i < APPROX_BITS with in_exact latched 0 SHALL use the approx cell; every other position SHALL use the exact cell.
REQ-017 The carry into position 0 SHALL be 0.
REQ-018 A shadow exact chain SHALL run in parallel on the same operands so out_err is available together with out_sum.
REQ-019 FSM states and transitions:
- IDLE -> RUN on in_valid & in_ready.
- RUN -> HOLD after the last chunk.
- HOLD -> IDLE on out_ready.
REQ-020 in_ready SHALL be 1 only in IDLE; in_a, in_b and in_exact SHALL be registered on acceptance and held stable until HOLD exits.
REQ-021 RUN SHALL process chunk k (bits k*CHUNK .. k*CHUNK+CHUNK-1) in its k-th cycle, carrying both chain carries in registers between cycles.
REQ-022 Latency: out_valid SHALL rise exactly WIDTH/CHUNK cycles after the accepting edge; with defaults, 4 cycles.
REQ-023 out_valid SHALL be 1 only in HOLD; out_sum and out_err SHALL stay stable while out_valid=1 and out_ready=0.
REQ-024 In HOLD, in_valid=1 SHALL be ignored (in_ready=0); a new operand can be accepted no earlier than the cycle after the out_ready handshake.
REQ-025 Arithmetic SHALL be unsigned with no truncation: out_sum is WIDTH+1 bits, and out_err is sign-extended to WIDTH+2 bits.
REQ-026 APPROX_BITS=0 or in_exact=1 SHALL give out_err = 0 for all operands.

Reset
REQ-027 When rst_n=0 at a clock edge, the FSM SHALL go to IDLE; in_ready SHALL be 1, and out_valid, out_sum and out_err SHALL be 0 starting that edge.
REQ-028 Reset during RUN or HOLD SHALL abort the operation with no result emitted; the first accept after reset SHALL be a fresh operation.

Verification (WIDTH=8, APPROX_BITS=6, CHUNK=2)
REQ-029 a=0x03, b=0x01, exact=0 -> out_sum=0x000, out_err=+4, out_valid 4 cycles after accept.
REQ-030 a=0xFF, b=0x01, exact=0 -> out_sum=0x100, out_err=0; a=0x00, b=0xFF -> out_sum=0x0FF, out_err=0.
REQ-031 a=0x03, b=0x01, exact=1 -> out_sum=0x004, out_err=0.
REQ-032 Hold out_ready=0 for 5 cycles in HOLD while in_valid=1 -> outputs stable, in_ready=0, no second accept.
REQ-033 Assert rst_n=0 in the 2nd RUN cycle -> next edge: IDLE, out_valid=0, out_sum=0, out_err=0, in_ready=1.
REQ-034 Random regression over 10k operand pairs across parameter sets (WIDTH=8/16, APPROX_BITS=0/4/WIDTH, CHUNK=1/2/4) against a bit-level reference model -> zero mismatches.
